// File: rtl/alu_pkg.sv
// ----------------------------------------------------------------------------
// alu_pkg
//   Shared types for the ALU-sharing arbiter and the ALU it fronts.
//   - alu_op_t    : ALUControl encodings understood by the shared ALU
//   - arb_state_t : arbiter FSM states (IDLE -> EXEC -> RESP -> IDLE)
//   - onehot2     : turns a 1-bit requester id into a 2-bit one-hot vector
// ----------------------------------------------------------------------------
package alu_pkg;

    localparam int REQ_NUM = 2;

    typedef enum logic [2:0] {
        ALU_AND = 3'b000,
        ALU_OR  = 3'b001,
        ALU_ADD = 3'b010,
        ALU_SUB = 3'b110
    } alu_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    function automatic logic [REQ_NUM-1:0] onehot2(input logic id);
        return id ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/alu.sv
// ----------------------------------------------------------------------------
// alu
//   Plain combinational ALU shared by the two clients of alu_share_arbiter.
//   Ports:
//     srca, srcb  in  N  operands
//     ctrl        in  3  ALUControl (000 AND, 001 OR, 010 ADD, 110 SUB)
//     result      out N  N-bit wrapping result; unlisted encodings give 0
// ----------------------------------------------------------------------------
module alu
    import alu_pkg::*;
#(
    parameter int N = 32
) (
    input  logic [N-1:0] srca,
    input  logic [N-1:0] srcb,
    input  logic [2:0]   ctrl,
    output logic [N-1:0] result
);

    always_comb begin
        result = '0;
        case (ctrl)
            ALU_AND: result = srca & srcb;
            ALU_OR:  result = srca | srcb;
            ALU_ADD: result = srca + srcb;
            ALU_SUB: result = srca - srcb;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/rr_arb2.sv
// ----------------------------------------------------------------------------
// rr_arb2
//   Two-way request picker.
//   Ports:
//     req         in  2  request vector
//     last_grant  in  1  id of the requester granted most recently
//     grant       out 2  one-hot grant (00 when no request)
//   Configuration macro: ALU_ARB_FIXED_PRIO_EN
//     defined   : requester 0 always wins a tie, last_grant is ignored
//     undefined : round-robin, a tie goes to the requester != last_grant
// ----------------------------------------------------------------------------
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] grant
);

`ifdef ALU_ARB_FIXED_PRIO_EN
    logic unused_last_grant;
    assign unused_last_grant = last_grant;

    always_comb begin
        grant = 2'b00;
        if (req[0]) begin
            grant = 2'b01;
        end else if (req[1]) begin
            grant = 2'b10;
        end
    end
`else
    always_comb begin
        grant = req;
        // Only a tie needs the history bit: hand it to whoever did not win last.
        if (req == 2'b11) begin
            grant = last_grant ? 2'b01 : 2'b10;
        end
    end
`endif

endmodule

// File: rtl/alu_share_arbiter.sv
// ----------------------------------------------------------------------------
// alu_share_arbiter
//   Shares one combinational ALU between two requesters. One operation is in
//   flight at a time: IDLE (accept) -> EXEC (ALU evaluates registered
//   operands) -> RESP (registered result held until taken) -> IDLE.
//   Ports:
//     clk, reset_n          clock, synchronous active-low reset
//     req_valid/req_ready   per-requester request handshake
//     req_srca/srcb/ctrl    per-requester operands and ALUControl
//     rsp_valid/rsp_ready   per-requester response handshake (rsp_valid one-hot)
//     rsp_data              registered result, qualified by rsp_valid
//     alu_srca/srcb/ctrl    registered operands to the shared ALU
//     alu_result            result from the shared ALU
//     dbg_state             current FSM state (arb_state_t encoding)
//   Configuration macro: ALU_ARB_FIXED_PRIO_EN (fixed priority to requester 0
//   when defined, round-robin otherwise; selected inside rr_arb2).
//
//   Handshake: a transfer happens on a rising edge where valid and ready are
//   both high. req_ready is combinational and only ever high in IDLE; a
//   requester holding valid without ready must keep its operands stable and
//   may drop valid at any time without effect. rsp_valid stays high with
//   rsp_data stable until the owning requester's rsp_ready is sampled high;
//   the other requester's rsp_ready is ignored.
// ----------------------------------------------------------------------------
module alu_share_arbiter
    import alu_pkg::*;
#(
    parameter int N = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [1:0][N-1:0] req_srca,
    input  logic [1:0][N-1:0] req_srcb,
    input  logic [1:0][2:0]   req_ctrl,
    output logic [1:0]        rsp_valid,
    input  logic [1:0]        rsp_ready,
    output logic [N-1:0]      rsp_data,
    output logic [N-1:0]      alu_srca,
    output logic [N-1:0]      alu_srcb,
    output logic [2:0]        alu_ctrl,
    input  logic [N-1:0]      alu_result,
    output logic [1:0]        dbg_state
);

    arb_state_t state;
    arb_state_t next_state;
    logic [1:0] grant;
    logic       grant_id;
    logic       last_grant;
    logic       rsp_id;
    logic       accept;
    logic       rsp_done;

    rr_arb2 u_arb (
        .req        (req_valid),
        .last_grant (last_grant),
        .grant      (grant)
    );

    assign grant_id  = grant[1];
    assign accept    = |req_ready;
    assign rsp_done  = (state == RESP) && rsp_ready[rsp_id];
    assign dbg_state = state;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept)   next_state = EXEC;
            EXEC:                  next_state = RESP;
            RESP:    if (rsp_done) next_state = IDLE;
            default:               next_state = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    // req_ready is also gated by reset_n so nothing looks accepted while
    // reset is asserted, even though the state already reads IDLE.
    always_comb begin
        req_ready = 2'b00;
        rsp_valid = 2'b00;
        if (state == IDLE && reset_n) begin
            req_ready = grant;
        end
        if (state == RESP) begin
            rsp_valid = onehot2(rsp_id);
        end
    end

    // ---------------- operand / result registers ----------------
    // The ALU only ever sees registered operands, so the requester is free to
    // change its inputs right after the accepting edge.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            alu_srca   <= '0;
            alu_srcb   <= '0;
            alu_ctrl   <= 3'b000;
            rsp_id     <= 1'b0;
            last_grant <= 1'b1;
            rsp_data   <= '0;
        end else begin
            if (accept) begin
                alu_srca   <= req_srca[grant_id];
                alu_srcb   <= req_srcb[grant_id];
                alu_ctrl   <= req_ctrl[grant_id];
                rsp_id     <= grant_id;
                last_grant <= grant_id;
            end
            if (state == EXEC) begin
                rsp_data <= alu_result;
            end
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// ----------------------------------------------------------------------------
// tb_alu_share_arbiter
//   Self-checking bench for alu_share_arbiter wired to the real alu (N=32).
//   Inputs are driven 1 time unit after a rising edge, outputs sampled 2 time
//   units after it. Honours ALU_ARB_FIXED_PRIO_EN for tie expectations.
// ----------------------------------------------------------------------------
module tb_alu_share_arbiter;

    localparam int N = 32;

`ifdef ALU_ARB_FIXED_PRIO_EN
    localparam bit FIXED_PRIO = 1'b1;
`else
    localparam bit FIXED_PRIO = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset_n;
    logic [1:0]        req_valid;
    logic [1:0]        req_ready;
    logic [1:0][N-1:0] req_srca;
    logic [1:0][N-1:0] req_srcb;
    logic [1:0][2:0]   req_ctrl;
    logic [1:0]        rsp_valid;
    logic [1:0]        rsp_ready;
    logic [N-1:0]      rsp_data;
    logic [N-1:0]      alu_srca;
    logic [N-1:0]      alu_srcb;
    logic [2:0]        alu_ctrl;
    logic [N-1:0]      alu_result;
    logic [1:0]        dbg_state;

    alu_share_arbiter #(.N(N)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_srca   (req_srca),
        .req_srcb   (req_srcb),
        .req_ctrl   (req_ctrl),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .alu_srca   (alu_srca),
        .alu_srcb   (alu_srcb),
        .alu_ctrl   (alu_ctrl),
        .alu_result (alu_result),
        .dbg_state  (dbg_state)
    );

    alu #(.N(N)) u_alu (
        .srca   (alu_srca),
        .srcb   (alu_srcb),
        .ctrl   (alu_ctrl),
        .result (alu_result)
    );

    // ---------------- scoreboard ----------------
    int total = 0;
    int bad   = 0;
    logic [N-1:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [31:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                            input logic [2:0] c);
        case (c)
            3'b000:  return a & b;
            3'b001:  return a | b;
            3'b010:  return a + b;
            3'b110:  return a - b;
            default: return 32'h0;
        endcase
    endfunction

    // Winner among valid requesters; last = id of previous winner.
    function automatic logic [1:0] pick(input logic [1:0] v, input int last);
        if (v == 2'b11) begin
            if (FIXED_PRIO) return 2'b01;
            return (last == 1) ? 2'b01 : 2'b10;
        end
        return v;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        @(posedge clk); #1;
        reset_n   = 1'b0;
        req_valid = 2'b11;
        rsp_ready = 2'b00;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("reset req_ready", 32'(req_ready), 32'h0);
        check("reset rsp_valid", 32'(rsp_valid), 32'h0);
        check("reset rsp_data",  rsp_data, 32'h0);
        check("reset alu_srca",  alu_srca, 32'h0);
        check("reset state",     32'(dbg_state), 32'h0);
        reset_n   = 1'b1;
        req_valid = 2'b00;
    endtask

    // Precondition: called shortly after a rising edge, inputs already driven,
    // DUT idle, rsp_ready set for the expected winner. Walks one full op.
    task automatic serve(input logic [1:0] g, input logic [31:0] exp_data,
                         input logic [31:0] exp_a, input string tag);
        #1;
        check({tag, " accept ready"}, 32'(req_ready), 32'(g));
        @(posedge clk); #1;
        req_valid = req_valid & ~g;
        #1;
        check({tag, " exec rsp_valid"}, 32'(rsp_valid), 32'h0);
        check({tag, " exec req_ready"}, 32'(req_ready), 32'h0);
        check({tag, " exec state"},     32'(dbg_state), 32'h1);
        check({tag, " exec alu_srca"},  alu_srca, exp_a);
        @(posedge clk); #2;
        check({tag, " resp rsp_valid"}, 32'(rsp_valid), 32'(g));
        check({tag, " resp rsp_data"},  rsp_data, exp_data);
        check({tag, " resp req_ready"}, 32'(req_ready), 32'h0);
        @(posedge clk); #2;
        check({tag, " done rsp_valid"}, 32'(rsp_valid), 32'h0);
        check({tag, " done state"},     32'(dbg_state), 32'h0);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        int          id;
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  ctrl;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[8];

    initial begin
        logic [1:0] g;
        int busy, age, pid, last;
        logic [1:0] granted, exp_ready, exp_rv;

        vecs[0] = '{0, 32'd5,          32'd7,          3'b010, 32'd12};
        vecs[1] = '{1, 32'd3,          32'd5,          3'b110, 32'hFFFF_FFFE};
        vecs[2] = '{0, 32'h0000_F0F0,  32'h0000_FF00,  3'b000, 32'h0000_F000};
        vecs[3] = '{1, 32'h0000_F0F0,  32'h0000_0F0F,  3'b001, 32'h0000_FFFF};
        vecs[4] = '{0, 32'hFFFF_FFFF,  32'd1,          3'b010, 32'h0};
        vecs[5] = '{1, 32'd0,          32'd1,          3'b110, 32'hFFFF_FFFF};
        vecs[6] = '{0, 32'h1234,       32'h5678,       3'b011, 32'h0};
        vecs[7] = '{1, 32'hAAAA,       32'h5555,       3'b111, 32'h0};

        reset_n   = 1'b0;
        req_valid = 2'b00;
        rsp_ready = 2'b00;
        req_srca  = '0;
        req_srcb  = '0;
        req_ctrl  = '0;

        // Reset with both requesters valid.
        do_reset();

        // Single operations from the table, other rsp_ready randomised.
        for (int i = 0; i < 8; i++) begin
            g = (vecs[i].id == 1) ? 2'b10 : 2'b01;
            req_valid = g;
            req_srca[vecs[i].id] = vecs[i].a;
            req_srcb[vecs[i].id] = vecs[i].b;
            req_ctrl[vecs[i].id] = vecs[i].ctrl;
            rsp_ready = g | 2'($urandom_range(0, 3));
            serve(g, vecs[i].exp, vecs[i].a, $sformatf("vec%0d", i));
        end

        // Backpressure: result held for 5 cycles, other requester waiting.
        req_valid   = 2'b01;
        req_srca[0] = 32'h0000_F0F0;
        req_srcb[0] = 32'h0000_FF00;
        req_ctrl[0] = 3'b000;
        rsp_ready   = 2'b10;
        #1;
        check("bp accept ready", 32'(req_ready), 32'h1);
        @(posedge clk); #1;
        req_valid   = 2'b10;
        req_srca[1] = 32'd3;
        req_srcb[1] = 32'd5;
        req_ctrl[1] = 3'b110;
        @(posedge clk); #1;
        for (int k = 0; k < 5; k++) begin
            #1;
            check("bp rsp_valid", 32'(rsp_valid), 32'h1);
            check("bp rsp_data",  rsp_data, 32'h0000_F000);
            check("bp req_ready", 32'(req_ready), 32'h0);
            @(posedge clk); #1;
        end
        rsp_ready = 2'b01;
        #1;
        check("bp release rsp_valid", 32'(rsp_valid), 32'h1);
        @(posedge clk); #2;
        check("bp idle rsp_valid", 32'(rsp_valid), 32'h0);
        check("bp idle state",     32'(dbg_state), 32'h0);
        check("bp idle req_ready", 32'(req_ready), 32'h2);
        rsp_ready = 2'b10;
        serve(2'b10, 32'hFFFF_FFFE, 32'd3, "sub wrap");
        req_valid = 2'b00;

        // Round-robin with both requesters continuously valid.
        do_reset();
        req_srca[0] = 32'd10; req_srcb[0] = 32'd1; req_ctrl[0] = 3'b010;
        req_srca[1] = 32'd10; req_srcb[1] = 32'd1; req_ctrl[1] = 3'b110;
        rsp_ready = 2'b11;
        for (int k = 0; k < 4; k++) begin
            req_valid = 2'b11;
            g = FIXED_PRIO ? 2'b01 : (((k % 2) == 1) ? 2'b10 : 2'b01);
            serve(g, (g == 2'b01) ? 32'd11 : 32'd9, 32'd10, $sformatf("rr%0d", k));
        end
        req_valid = 2'b00;

        // Reset while a result is pending.
        req_valid   = 2'b10;
        req_srca[1] = 32'h0000_F0F0;
        req_srcb[1] = 32'h0000_0F0F;
        req_ctrl[1] = 3'b001;
        rsp_ready   = 2'b00;
        #1;
        check("rst-resp accept ready", 32'(req_ready), 32'h2);
        @(posedge clk); #1;
        req_valid = 2'b00;
        @(posedge clk); #2;
        check("rst-resp pending rsp_valid", 32'(rsp_valid), 32'h2);
        check("rst-resp pending rsp_data",  rsp_data, 32'h0000_FFFF);
        reset_n     = 1'b0;
        req_valid   = 2'b11;
        req_srca[0] = 32'd5;
        req_srcb[0] = 32'd7;
        req_ctrl[0] = 3'b010;
        #1;
        check("rst-resp ready in reset", 32'(req_ready), 32'h0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        #1;
        check("rst-resp rsp_valid", 32'(rsp_valid), 32'h0);
        check("rst-resp rsp_data",  rsp_data, 32'h0);
        check("rst-resp tie grant", 32'(req_ready), 32'h1);
        rsp_ready = 2'b01;
        serve(2'b01, 32'd12, 32'd5, "post-reset");
        req_valid = 2'b00;

        // Random traffic against the behavioural model.
        do_reset();
        busy = 0; age = 0; pid = 0; last = 1; granted = 2'b00;
        exp_q.delete();
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(posedge clk); #1;
            for (int i = 0; i < 2; i++) begin
                if (req_valid[i] && !granted[i]) begin
                    if ($urandom_range(0, 3) == 0) req_valid[i] = 1'b0;
                end else begin
                    req_valid[i] = 1'($urandom_range(0, 1));
                    req_srca[i]  = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 15));
                    req_srcb[i]  = $urandom;
                    req_ctrl[i]  = 3'($urandom_range(0, 7));
                end
            end
            rsp_ready = 2'($urandom_range(0, 3));
            #1;
            exp_ready = (busy != 0) ? 2'b00 : pick(req_valid, last);
            exp_rv    = (busy != 0 && age >= 1) ? ((pid == 1) ? 2'b10 : 2'b01) : 2'b00;
            check("rand req_ready", 32'(req_ready), 32'(exp_ready));
            check("rand rsp_valid", 32'(rsp_valid), 32'(exp_rv));
            if (exp_rv != 2'b00 && exp_q.size() > 0) begin
                check("rand rsp_data", rsp_data, exp_q[0]);
            end
            granted = 2'b00;
            if (busy == 0 && exp_ready != 2'b00) begin
                busy = 1;
                age  = 0;
                pid  = exp_ready[1] ? 1 : 0;
                last = pid;
                exp_q.push_back(alu_ref(req_srca[pid], req_srcb[pid], req_ctrl[pid]));
                granted = exp_ready;
            end else if (busy != 0) begin
                if (age >= 1 && rsp_ready[pid]) begin
                    busy = 0;
                    void'(exp_q.pop_front());
                end else begin
                    age = 1;
                end
            end
        end
        req_valid = 2'b00;
        rsp_ready = 2'b11;
        repeat (4) @(posedge clk);

        // ---------------- final report ----------------
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
